muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU; the datapath stalls on busy and captures result on done.
- Generalises the ALU in width (XLEN) and in throughput (bits retired per iteration), with a start/busy/done handshake and flush.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per CALC cycle, start/busy/done handshake with flush.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic              r_sa, r_sb;
  logic [XLEN-1:0]   r_acc, r_lo, r_opnd, r_result;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_special, w_sa, w_sb, w_div_zero, w_ovf;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_fix_res;
  logic [XLEN-1:0]   w_acc_nx, w_lo_nx, w_addend, w_quo, w_rem;
  logic [XLEN:0]     w_sum, w_rsh;
  logic [2*XLEN-1:0] w_prod;

  assign busy   = (r_state == CALC) || (r_state == FIXUP);
  assign done   = (r_state == DONE);
  assign result = r_result;

  // Signed operands: a for DIV/REM/MULH/MULHSU, b for DIV/REM/MULH.
  assign w_sa       = a[XLEN-1] & ((op == 3'b100) || (op == 3'b110) || (op == 3'b001) || (op == 3'b010));
  assign w_sb       = b[XLEN-1] & ((op == 3'b100) || (op == 3'b110) || (op == 3'b001));
  assign w_mag_a    = w_sa ? -a : a;
  assign w_mag_b    = w_sb ? -b : b;
  assign w_div_zero = op[2] && (b == '0);
  assign w_ovf      = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero)
      w_spec_res = op[1] ? a : '1;
    else if (w_ovf)
      w_spec_res = op[1] ? '0 : a;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (start && !flush) begin
          w_accept = 1'b1;
          w_next   = w_special ? DONE : CALC;
        end
      end
      CALC:    if (flush) w_next = IDLE;
               else if (r_cnt == CW'(N-1)) w_next = FIXUP;
      FIXUP:   w_next = flush ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // r_acc/r_lo hold {product hi, lo} when multiplying, {remainder, quotient} when dividing.
  always_comb begin
    w_acc_nx = r_acc;
    w_lo_nx  = r_lo;
    w_sum    = '0;
    w_rsh    = '0;
    w_addend = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (!r_op[2]) begin
        w_addend = w_lo_nx[0] ? r_opnd : '0;
        w_sum    = {1'b0, w_acc_nx} + {1'b0, w_addend};
        w_lo_nx  = {w_sum[0], w_lo_nx[XLEN-1:1]};
        w_acc_nx = w_sum[XLEN:1];
      end else begin
        w_rsh   = {w_acc_nx, w_lo_nx[XLEN-1]};
        w_lo_nx = {w_lo_nx[XLEN-2:0], 1'b0};
        if (w_rsh >= {1'b0, r_opnd}) begin
          w_rsh      = w_rsh - {1'b0, r_opnd};
          w_lo_nx[0] = 1'b1;
        end
        w_acc_nx = w_rsh[XLEN-1:0];
      end
    end
  end

  always_comb begin
    w_prod = {r_acc, r_lo};
    if (r_sa ^ r_sb)
      w_prod = -w_prod;
    w_quo = (r_sa ^ r_sb) ? -r_lo : r_lo;
    w_rem = r_sa ? -r_acc : r_acc;
    if (r_op[2])
      w_fix_res = r_op[1] ? w_rem : w_quo;
    else
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_lo   <= op[2] ? w_mag_a : w_mag_b;
        r_opnd <= op[2] ? w_mag_b : w_mag_a;
        if (w_special)
          r_result <= w_spec_res;
      end else if (r_state == CALC) begin
        r_acc <= w_acc_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt + CW'(1);
      end else if ((r_state == FIXUP) && !flush) begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 1-bit/cycle and a 4-bit/cycle instance
// checked against hand-computed RV32M results, latencies and handshake sequences.
module tb_muldiv_unit;

  logic        clk, rst;
  logic [1:0]  start_v, flush_v;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy0, busy1, done0, done1;
  logic [31:0] res0, res1;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res [2];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs [16];

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_i), .a(a_i), .b(b_i),
    .flush(flush_v[0]), .busy(busy0), .done(done0), .result(res0)
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_i), .a(a_i), .b(b_i),
    .flush(flush_v[1]), .busy(busy1), .done(done1), .result(res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic f_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic f_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  function automatic logic [31:0] f_res(input int d);
    return (d == 0) ? res0 : res1;
  endfunction

  function automatic int lat_of(input int d);
    return ((d == 0) ? 32 : 8) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int from, input int maxc, output int lat);
    lat = from;
    while (!f_done(d) && lat < maxc) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] mask, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ex, input bit sp, input string nm);
    int   lat  [2];
    int   bcnt [2];
    logic after[2];
    logic bz   [2];
    for (int d = 0; d < 2; d++) begin
      lat[d] = -1; bcnt[d] = 0; after[d] = 1'b1; bz[d] = 1'b1;
    end
    op_i = o; a_i = av; b_i = bv; start_v = mask;
    tick();
    start_v = '0;
    for (int c = 0; c <= 36; c++) begin
      if (c > 0) tick();
      for (int d = 0; d < 2; d++) begin
        if (mask[d]) begin
          if (lat[d] < 0) begin
            if (f_done(d)) begin
              lat[d] = c;
              bz[d]  = f_busy(d);
            end else if (f_busy(d)) begin
              bcnt[d]++;
            end
          end else if (c == lat[d] + 1) begin
            after[d] = f_done(d);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (mask[d]) begin
        chk($sformatf("%s_latency[d%0d]", nm, d), lat[d], sp ? 32'd0 : 32'(lat_of(d)));
        chk($sformatf("%s_busy_cycles[d%0d]", nm, d), bcnt[d], sp ? 32'd0 : 32'(lat_of(d)));
        chk($sformatf("%s_busy_with_done[d%0d]", nm, d), 32'(bz[d]), 32'd0);
        chk($sformatf("%s_done_pulse[d%0d]", nm, d), 32'(after[d]), 32'd0);
        chk($sformatf("%s_result[d%0d]", nm, d), f_res(d), ex);
        last_res[d] = ex;
      end
    end
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[14] = '{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};
    vecs[15] = '{3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0};

    rst = 1'b1; start_v = '0; flush_v = '0; op_i = '0; a_i = '0; b_i = '0;
    last_res[0] = '0; last_res[1] = '0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_busy[d%0d]", d), 32'(f_busy(d)), 32'd0);
      chk($sformatf("reset_done[d%0d]", d), 32'(f_done(d)), 32'd0);
      chk($sformatf("reset_result[d%0d]", d), f_res(d), 32'd0);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++)
      run_op(2'b11, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special,
             $sformatf("vec%0d", i));

    for (int d = 0; d < 2; d++) begin
      // Flush part-way through a DIV: no done, result untouched.
      op_i = 3'b100; a_i = 32'd100; b_i = 32'd7; start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      repeat ((d == 0) ? 10 : 4) tick();
      flush_v[d] = 1'b1;
      tick();
      flush_v[d] = 1'b0;
      chk($sformatf("flush_busy[d%0d]", d), 32'(f_busy(d)), 32'd0);
      seen = 1'b0;
      repeat (40) begin
        tick();
        if (f_done(d)) seen = 1'b1;
      end
      chk($sformatf("flush_no_done[d%0d]", d), 32'(seen), 32'd0);
      chk($sformatf("flush_result_held[d%0d]", d), f_res(d), last_res[d]);
      run_op(d == 0 ? 2'b01 : 2'b10, 3'b000, 32'd3, 32'd4, 32'd12, 1'b0,
             $sformatf("after_flush_mul"));

      // Back-to-back accept from DONE, then start+flush in DONE.
      op_i = 3'b101; a_i = 32'd100; b_i = 32'd7; start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      wait_done(d, 0, 40, lat);
      chk($sformatf("b2b_first_latency[d%0d]", d), lat, 32'(lat_of(d)));
      chk($sformatf("b2b_first_result[d%0d]", d), f_res(d), 32'd14);
      op_i = 3'b011; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      chk($sformatf("b2b_accepted_busy[d%0d]", d), 32'(f_busy(d)), 32'd1);
      chk($sformatf("b2b_result_held[d%0d]", d), f_res(d), 32'd14);
      wait_done(d, 0, 40, lat);
      chk($sformatf("b2b_second_latency[d%0d]", d), lat, 32'(lat_of(d)));
      chk($sformatf("b2b_second_result[d%0d]", d), f_res(d), 32'hFFFF_FFFE);
      start_v[d] = 1'b1; flush_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0; flush_v[d] = 1'b0;
      chk($sformatf("done_flush_busy[d%0d]", d), 32'(f_busy(d)), 32'd0);
      chk($sformatf("done_flush_done[d%0d]", d), 32'(f_done(d)), 32'd0);
      chk($sformatf("done_flush_result[d%0d]", d), f_res(d), 32'hFFFF_FFFE);

      // Start pulsed while busy is ignored.
      op_i = 3'b000; a_i = 32'd7; b_i = 32'hFFFF_FFFD; start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      repeat (3) tick();
      op_i = 3'b101; a_i = 32'd100; b_i = 32'd7; start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      wait_done(d, 4, 40, lat);
      chk($sformatf("busy_start_latency[d%0d]", d), lat, 32'(lat_of(d)));
      chk($sformatf("busy_start_result[d%0d]", d), f_res(d), 32'hFFFF_FFEB);
      repeat (3) tick();
      chk($sformatf("busy_start_not_queued[d%0d]", d), 32'({f_busy(d), f_done(d)}), 32'd0);
      last_res[d] = 32'hFFFF_FFEB;
    end

    // Asynchronous reset mid-op clears outputs immediately.
    op_i = 3'b101; a_i = 32'd100; b_i = 32'd7; start_v = 2'b11;
    tick();
    start_v = '0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midop_reset_busy[d%0d]", d), 32'(f_busy(d)), 32'd0);
      chk($sformatf("midop_reset_done[d%0d]", d), 32'(f_done(d)), 32'd0);
      chk($sformatf("midop_reset_result[d%0d]", d), f_res(d), 32'd0);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("post_reset_idle[d%0d]", d), 32'({f_busy(d), f_done(d)}), 32'd0);
    run_op(2'b11, 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, "post_reset_mul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
